// File: rtl/ft245_sff_emulator.sv
// Device-side model of the FT245 synchronous FIFO interface.
// Two byte FIFOs bridge the FT pins to a valid/ready host byte stream.
module ft245_sff_emulator #(
    parameter int unsigned RX_AW = 4,
    parameter int unsigned TX_AW = 4
) (
    input  logic       Clk,
    input  logic       ARst,
    output logic       RXFn,
    output logic       TXEn,
    input  logic       RDn,
    input  logic       OEn,
    input  logic       WRn,
    output logic [7:0] DOUT,
    output logic       DOUTEn,
    input  logic [7:0] DIN,
    input  logic [7:0] HostInData,
    input  logic       HostInValid,
    output logic       HostInReady,
    output logic [7:0] HostOutData,
    output logic       HostOutValid,
    input  logic       HostOutReady,
    output logic       ErrUnderrun,
    output logic       ErrOverrun,
    output logic       ErrBus
);

    localparam logic [RX_AW:0] RX_FULL = {1'b1, {RX_AW{1'b0}}};
    localparam logic [TX_AW:0] TX_FULL = {1'b1, {TX_AW{1'b0}}};

    logic [7:0]       rx_mem [2**RX_AW];
    logic [7:0]       tx_mem [2**TX_AW];

    logic [RX_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
    logic [TX_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
    logic             rxf_q, rxf_d, txe_q, txe_d;
    logic             eu_q, eu_d, eo_q, eo_d, eb_q, eb_d;

    logic rd_req, rx_pop, rx_ready, rx_push;
    logic wr_req, tx_pop, tx_room, tx_push;

    always_comb begin
        rd_req   = ~OEn & ~RDn;
        rx_pop   = rd_req & (rx_cnt_q != '0);
        // A pop frees a slot this cycle, so a full FIFO still accepts a push.
        rx_ready = (rx_cnt_q != RX_FULL) | rx_pop;
        rx_push  = HostInValid & rx_ready;

        wr_req   = ~WRn;
        tx_pop   = HostOutReady & (tx_cnt_q != '0);
        tx_room  = (tx_cnt_q != TX_FULL) | tx_pop;
        tx_push  = wr_req & OEn & tx_room;

        rx_wp_d  = rx_wp_q + RX_AW'(rx_push);
        rx_rp_d  = rx_rp_q + RX_AW'(rx_pop);
        rx_cnt_d = rx_cnt_q + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);

        tx_wp_d  = tx_wp_q + TX_AW'(tx_push);
        tx_rp_d  = tx_rp_q + TX_AW'(tx_pop);
        tx_cnt_d = tx_cnt_q + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);

        rxf_d    = (rx_cnt_d == '0);
        txe_d    = (tx_cnt_d == TX_FULL);

        eu_d     = eu_q | (rd_req & (rx_cnt_q == '0));
        eo_d     = eo_q | (wr_req & OEn & ~tx_room);
        eb_d     = eb_q | (wr_req & ~OEn);
    end

    always_ff @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rxf_q    <= 1'b1;
            txe_q    <= 1'b1;
            eu_q     <= 1'b0;
            eo_q     <= 1'b0;
            eb_q     <= 1'b0;
        end else begin
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rxf_q    <= rxf_d;
            txe_q    <= txe_d;
            eu_q     <= eu_d;
            eo_q     <= eo_d;
            eb_q     <= eb_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge Clk) begin
        if (rx_push && !ARst) begin
            rx_mem[rx_wp_q] <= HostInData;
        end
        if (tx_push && !ARst) begin
            tx_mem[tx_wp_q] <= DIN;
        end
    end

    assign RXFn         = rxf_q;
    assign TXEn         = txe_q;
    assign HostInReady  = rx_ready & ~ARst;
    assign HostOutValid = tx_cnt_q != '0;
    assign HostOutData  = tx_mem[tx_rp_q];
    assign DOUTEn       = ~OEn;
    assign DOUT         = (~OEn & ~ARst) ? rx_mem[rx_rp_q] : 8'h00;
    assign ErrUnderrun  = eu_q;
    assign ErrOverrun   = eo_q;
    assign ErrBus       = eb_q;

endmodule

// File: tb/tb_ft245_sff_emulator.sv
// Scoreboard bench for ft245_sff_emulator: queue-based reference model
// updated at each edge, monitor compares outputs at the falling edge.
module tb_ft245_sff_emulator;

    localparam int DEPTH = 16;

    logic       Clk = 1'b0;
    logic       ARst = 1'b1;
    logic       RXFn, TXEn, DOUTEn, HostInReady, HostOutValid;
    logic       ErrUnderrun, ErrOverrun, ErrBus;
    logic [7:0] DOUT, HostOutData;
    logic       RDn = 1'b1, OEn = 1'b1, WRn = 1'b1;
    logic [7:0] DIN = 8'h00, HostInData = 8'h00;
    logic       HostInValid = 1'b0, HostOutReady = 1'b0;

    ft245_sff_emulator #(.RX_AW(4), .TX_AW(4)) dut (
        .Clk(Clk), .ARst(ARst), .RXFn(RXFn), .TXEn(TXEn),
        .RDn(RDn), .OEn(OEn), .WRn(WRn), .DOUT(DOUT), .DOUTEn(DOUTEn),
        .DIN(DIN), .HostInData(HostInData), .HostInValid(HostInValid),
        .HostInReady(HostInReady), .HostOutData(HostOutData),
        .HostOutValid(HostOutValid), .HostOutReady(HostOutReady),
        .ErrUnderrun(ErrUnderrun), .ErrOverrun(ErrOverrun), .ErrBus(ErrBus)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    int m_rx = 0, m_tx = 0;
    bit m_rxf = 1, m_txe = 1, m_eu = 0, m_eo = 0, m_eb = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO occupancy and sticky errors from the pin rules.
    always @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            m_rx = 0; m_tx = 0;
            m_rxf = 1; m_txe = 1;
            m_eu = 0; m_eo = 0; m_eb = 0;
            exp_rx.delete();
            exp_tx.delete();
        end else begin
            bit rpop, rpush, tpop, tpush;
            rpop  = !OEn && !RDn && m_rx != 0;
            rpush = HostInValid && (m_rx != DEPTH || rpop);
            if (!OEn && !RDn && m_rx == 0) m_eu = 1;
            if (rpush) exp_rx.push_back(HostInData);
            m_rx = m_rx + int'(rpush) - int'(rpop);

            tpop  = HostOutReady && m_tx != 0;
            tpush = 0;
            if (!WRn && !OEn) m_eb = 1;
            else if (!WRn) begin
                if (m_tx != DEPTH || tpop) tpush = 1;
                else m_eo = 1;
            end
            if (tpush) exp_tx.push_back(DIN);
            m_tx = m_tx + int'(tpush) - int'(tpop);

            m_rxf = (m_rx == 0);
            m_txe = (m_tx == DEPTH);
        end
    end

    // Monitor: compare DUT outputs mid-cycle; pop scoreboard on transfers.
    always @(negedge Clk) begin
        if (ARst) begin
            chk("rst_RXFn", RXFn, 1);
            chk("rst_TXEn", TXEn, 1);
            chk("rst_HostInReady", HostInReady, 0);
            chk("rst_HostOutValid", HostOutValid, 0);
            chk("rst_DOUT", DOUT, 0);
            chk("rst_errs", {ErrUnderrun, ErrOverrun, ErrBus}, 0);
        end else begin
            chk("RXFn", RXFn, m_rxf);
            chk("TXEn", TXEn, m_txe);
            chk("HostInReady", HostInReady,
                (m_rx != DEPTH) || (!OEn && !RDn && m_rx != 0));
            chk("HostOutValid", HostOutValid, m_tx != 0);
            chk("ErrUnderrun", ErrUnderrun, m_eu);
            chk("ErrOverrun", ErrOverrun, m_eo);
            chk("ErrBus", ErrBus, m_eb);
            chk("DOUTEn", DOUTEn, !OEn);
            if (OEn) begin
                chk("DOUT_idle", DOUT, 0);
            end else if (m_rx != 0 && exp_rx.size() != 0) begin
                chk("DOUT", DOUT, exp_rx[0]);
                if (!RDn) void'(exp_rx.pop_front());
            end
            if (m_tx != 0 && exp_tx.size() != 0) begin
                chk("HostOutData", HostOutData, exp_tx[0]);
                if (HostOutReady) void'(exp_tx.pop_front());
            end
        end
    end

    task automatic drive(input logic hv, input logic [7:0] hd,
                         input logic oen, input logic rdn, input logic wrn,
                         input logic [7:0] din, input logic hor);
        HostInValid  = hv;
        HostInData   = hd;
        OEn          = oen;
        RDn          = rdn;
        WRn          = wrn;
        DIN          = din;
        HostOutReady = hor;
        @(posedge Clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 8'h00, 1, 1, 1, 8'h00, 0);
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #2 ARst = 1'b0;
        idle(2);

        // Host->FPGA burst, then 16 back-to-back reads.
        for (int i = 1; i <= 16; i++) drive(1, 8'(i), 1, 1, 1, 8'h00, 0);
        idle(2);
        for (int i = 0; i < 16; i++) drive(0, 8'h00, 0, 0, 1, 8'h00, 0);
        drive(0, 8'h00, 0, 1, 1, 8'h00, 0);
        idle(1);

        // FPGA->host burst of 17 writes, last one overruns.
        for (int i = 0; i < 17; i++) drive(0, 8'h00, 1, 1, 0, 8'(8'hA0 + i), 0);
        idle(1);
        for (int i = 0; i < 17; i++) drive(0, 8'h00, 1, 1, 1, 8'h00, 1);

        // Full RX FIFO with simultaneous push and pop across the wrap.
        for (int i = 0; i < 16; i++)
            drive(1, 8'($urandom), 1, 1, 1, 8'h00, 0);
        for (int i = 0; i < 20; i++)
            drive(1, 8'($urandom), 0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 16; i++) drive(0, 8'h00, 0, 0, 1, 8'h00, 0);

        // Underrun on empty FIFO, then bus contention.
        drive(0, 8'h00, 0, 0, 1, 8'h00, 0);
        idle(1);
        drive(0, 8'h00, 0, 1, 0, 8'h55, 0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++)
            drive(1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom), 1'($urandom_range(0, 3) != 0),
                  8'($urandom), 1'($urandom));

        // Reset mid-burst with 5 bytes queued.
        ARst = 1'b1;
        idle(2);
        ARst = 1'b0;
        for (int i = 0; i < 5; i++) drive(1, 8'(8'h30 + i), 1, 1, 0, 8'(i), 0);
        HostInValid = 1'b1;
        OEn = 1'b0;
        RDn = 1'b0;
        #1 ARst = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #2 ARst = 1'b0;
        idle(3);
        drive(1, 8'h77, 1, 1, 1, 8'h00, 0);
        drive(0, 8'h00, 0, 0, 1, 8'h00, 0);
        idle(2);

        @(negedge Clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
